// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Latency: none, this is a plain signal bundle.
// Backpressure: req is held until gnt; load data returns on rvalid one or more cycles after gnt.
// Signals: req/we/addr/be/wdata from master; gnt/rvalid/rdata from slave.
interface mem_stage_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the dmem bus, steers and extends load data.
// Latency: 1 cycle for non-memory ops; memory ops complete after gnt (stores) or rvalid (loads).
// Backpressure: stall_o holds upstream while an access is outstanding; aborts after DMEM_TIMEOUT.
// Ports: clk_i/rst_i; EX-MEM register inputs (pc, instr, operation, rd port, store enable,
//        address, store data, stall marker); dmem master interface; stall_o; MEM-WB register
//        outputs (pc, instr, operation, rd port) and the misaligned_o / bus_err_o event pulses.

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        UNKNOWN = 6'd0,
        ADD, SUB, ADDI, LUI,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, JAL
    } operation_e;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            valid;
    } rd_port_t;
endpackage

module mem_stage
    import riscv_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pcM_i,
    input  logic [XLEN-1:0] instrM_i,
    input  operation_e      operationM_i,
    input  rd_port_t        rdM_port_i,
    input  logic            memM_wrt_ena_i,
    input  logic [XLEN-1:0] memM_addr_i,
    input  logic [XLEN-1:0] memM_wrt_data_i,
    input  logic            stallM_i,
    mem_stage_if.master     dmem,
    output logic            stall_o,
    output logic [XLEN-1:0] pcM_o,
    output logic [XLEN-1:0] instrM_o,
    output operation_e      operationM_o,
    output rd_port_t        rdM_port_o,
    output logic            misaligned_o,
    output logic            bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(DMEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, instr_q;
    operation_e      op_q;
    rd_port_t        rd_q, rd_d;
    logic            misaligned_q, bus_err_q;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic is_load, is_store, is_half, is_word;
    logic access_vld, misalign, start, mis_evt;

    assign is_load  = operationM_i inside {LB, LH, LW, LBU, LHU};
    assign is_store = operationM_i inside {SB, SH, SW};
    assign is_half  = operationM_i inside {LH, LHU, SH};
    assign is_word  = operationM_i inside {LW, SW};

    assign access_vld = !stallM_i && ((is_load && rdM_port_i.valid) ||
                                      (is_store && memM_wrt_ena_i));
    assign misalign   = (is_half && memM_addr_i[0]) ||
                        (is_word && (memM_addr_i[1:0] != 2'b00));

    // Only IDLE can accept a new access; in the wait states the same op is being serviced.
    assign start   = (state_q == IDLE) && access_vld && !misalign;
    assign mis_evt = (state_q == IDLE) && access_vld && misalign;

    // ------------------------------------------------------------------
    // Byte lanes
    // ------------------------------------------------------------------
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = memM_wrt_data_i;
        if (operationM_i inside {SB, LB, LBU}) begin
            be_c    = 4'b0001 << memM_addr_i[1:0];
            wdata_c = {4{memM_wrt_data_i[7:0]}};
        end else if (is_half) begin
            be_c    = 4'b0011 << memM_addr_i[1:0];
            wdata_c = {2{memM_wrt_data_i[15:0]}};
        end
    end

    // Upstream holds its inputs while stalled, so the address is still valid when rvalid arrives.
    assign ld_byte = dmem.rdata[{memM_addr_i[1:0], 3'b000} +: 8];
    assign ld_half = dmem.rdata[{memM_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = dmem.rdata;
        case (operationM_i)
            LB:      ld_ext = {{24{ld_byte[7]}}, ld_byte};
            LBU:     ld_ext = {24'h0, ld_byte};
            LH:      ld_ext = {{16{ld_half[15]}}, ld_half};
            LHU:     ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem.rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic req_c, stall_c, load_done, abort;

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        load_done = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    req_c = 1'b1;
                    if (dmem.gnt) begin
                        // A granted store is finished; only loads keep the pipe held.
                        if (is_load) begin
                            stall_c = 1'b1;
                            state_d = WAIT_RVALID;
                        end
                    end else begin
                        stall_c = 1'b1;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (cnt_q == TIMEOUT_C) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_c = 1'b1;
                    if (dmem.gnt) begin
                        if (is_load) begin
                            stall_c = 1'b1;
                            state_d = WAIT_RVALID;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            WAIT_RVALID: begin
                if (cnt_q == TIMEOUT_C) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (dmem.rvalid) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state change and only advances while waiting.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Gating with rst_i drops the request in the very cycle reset is raised, even though
    // the upstream may still present a memory op to the (already reset) IDLE state.
    assign dmem.req   = req_c && !rst_i;
    assign stall_o    = stall_c && !rst_i;
    assign dmem.we    = dmem.req && is_store;
    assign dmem.addr  = dmem.req ? {memM_addr_i[XLEN-1:2], 2'b00} : '0;
    assign dmem.be    = dmem.req ? be_c : 4'b0000;
    assign dmem.wdata = dmem.req ? wdata_c : '0;

    // ------------------------------------------------------------------
    // MEM-WB register
    // ------------------------------------------------------------------
    always_comb begin
        rd_d = rdM_port_i;
        if (load_done) begin
            rd_d.data  = ld_ext;
            rd_d.valid = 1'b1;
        end else if (is_store || mis_evt || abort) begin
            rd_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            pc_q         <= '0;
            instr_q      <= '0;
            op_q         <= UNKNOWN;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            misaligned_q <= mis_evt;
            bus_err_q    <= abort;
            if (stall_o) begin
                // Op still in flight: hand WB a bubble.
                pc_q    <= '0;
                instr_q <= '0;
                op_q    <= UNKNOWN;
                rd_q    <= '0;
            end else begin
                pc_q    <= pcM_i;
                instr_q <= instrM_i;
                op_q    <= operationM_i;
                rd_q    <= rd_d;
            end
        end
    end

    assign pcM_o        = pc_q;
    assign instrM_o     = instr_q;
    assign operationM_o = op_q;
    assign rdM_port_o   = rd_q;
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import riscv_pkg::*;

    logic            clk;
    logic            rst;
    logic [31:0]     pc, instr, addr, wdata;
    operation_e      op;
    rd_port_t        rd_in;
    logic            wrt_ena, stall_m;
    logic            stall_o, mis_o, berr_o;
    logic [31:0]     pc_o, instr_o;
    operation_e      op_o;
    rd_port_t        rd_o;

    int n_chk  = 0;
    int n_pass = 0;
    int stalls, reqs;

    mem_stage_if bus ();

    mem_stage #(.DMEM_TIMEOUT(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pcM_i           (pc),
        .instrM_i        (instr),
        .operationM_i    (op),
        .rdM_port_i      (rd_in),
        .memM_wrt_ena_i  (wrt_ena),
        .memM_addr_i     (addr),
        .memM_wrt_data_i (wdata),
        .stallM_i        (stall_m),
        .dmem            (bus),
        .stall_o         (stall_o),
        .pcM_o           (pc_o),
        .instrM_o        (instr_o),
        .operationM_o    (op_o),
        .rdM_port_o      (rd_o),
        .misaligned_o    (mis_o),
        .bus_err_o       (berr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic idle();
        op          = UNKNOWN;
        pc          = 32'h0;
        instr       = 32'h0;
        rd_in       = '0;
        wrt_ena     = 1'b0;
        addr        = 32'h0;
        wdata       = 32'h0;
        stall_m     = 1'b0;
        bus.gnt     = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
    endtask

    // Hold a load op (rd x9) until stall_o drops; gnt in cycle g, rvalid in cycle r
    // (cycle 0 = first cycle the op is presented). Negative g/r: never.
    task automatic run_load(input operation_e o, input logic [31:0] a, input logic [31:0] word,
                            input int g, input int r, output int n_stall, output int n_req);
        n_stall = 0;
        n_req   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op          = o;
            rd_in.addr  = 5'd9;
            rd_in.data  = 32'h0;
            rd_in.valid = 1'b1;
            wrt_ena     = 1'b0;
            addr        = a;
            stall_m     = 1'b0;
            bus.gnt     = (i == g);
            bus.rvalid  = (i == r);
            bus.rdata   = (i == r) ? word : 32'h0;
            #1;
            if (bus.req) n_req++;
            if (!stall_o) break;
            n_stall++;
        end
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic run_store(input operation_e o, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        op          = o;
        rd_in       = '0;
        wrt_ena     = 1'b1;
        addr        = a;
        wdata       = d;
        stall_m     = 1'b0;
        bus.gnt     = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        // Reset state
        chk("rst_req",   bus.req, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_rd",    rd_o,    38'h0);
        chk("rst_op",    op_o,    UNKNOWN);
        chk("rst_pc",    pc_o,    32'h0);
        chk("rst_flags", {mis_o, berr_o}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // ADDI x5 = 7: one-cycle pass-through, no stall
        @(negedge clk);
        op = ADDI; pc = 32'h40; instr = 32'h00700293;
        rd_in.addr = 5'd5; rd_in.data = 32'd7; rd_in.valid = 1'b1;
        #1;
        chk("addi_stall", stall_o, 1'b0);
        chk("addi_req",   bus.req, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("addi_rd",    rd_o,  {5'd5, 32'd7, 1'b1});
        chk("addi_pc",    pc_o,  32'h40);
        chk("addi_instr", instr_o, 32'h00700293);
        chk("addi_op",    op_o,  ADDI);

        // SW 0x100 granted immediately
        run_store(SW, 32'h100, 32'hDEADBEEF);
        chk("sw_req",   bus.req,   1'b1);
        chk("sw_we",    bus.we,    1'b1);
        chk("sw_addr",  bus.addr,  32'h100);
        chk("sw_be",    bus.be,    4'b1111);
        chk("sw_wdata", bus.wdata, 32'hDEADBEEF);
        chk("sw_stall", stall_o,   1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("sw_rdvld", rd_o.valid, 1'b0);
        chk("sw_op",    op_o,       SW);

        // LB 0x103: gnt in cycle 2, rvalid in cycle 6 -> 6 stall cycles
        run_load(LB, 32'h103, 32'h80123456, 2, 6, stalls, reqs);
        chk("lb_stalls", stalls, 6);
        chk("lb_reqs",   reqs,   3);
        chk("lb_rd",     rd_o,   {5'd9, 32'hFFFFFF80, 1'b1});
        chk("lb_op",     op_o,   LB);

        // LHU 0x102: upper half, zero-extended
        run_load(LHU, 32'h102, 32'hBEEF1234, 0, 1, stalls, reqs);
        chk("lhu_stalls", stalls, 1);
        chk("lhu_rd",     rd_o,   {5'd9, 32'h0000BEEF, 1'b1});

        // LH 0x100: lower half, sign-extended
        run_load(LH, 32'h100, 32'h12348765, 0, 1, stalls, reqs);
        chk("lh_rd", rd_o, {5'd9, 32'hFFFF8765, 1'b1});

        // SH 0x102 and SB 0x101 lane steering
        run_store(SH, 32'h102, 32'h00001234);
        chk("sh_be",    bus.be,    4'b1100);
        chk("sh_wdata", bus.wdata, 32'h12341234);
        chk("sh_addr",  bus.addr,  32'h100);
        run_store(SB, 32'h101, 32'h000000AB);
        chk("sb_be",    bus.be,    4'b0010);
        chk("sb_wdata", bus.wdata, 32'hABABABAB);
        @(negedge clk);
        idle();

        // LW 0x101: misaligned, dropped without a request
        @(negedge clk);
        op = LW; addr = 32'h101;
        rd_in.addr = 5'd3; rd_in.data = 32'h0; rd_in.valid = 1'b1;
        #1;
        chk("mis_req",   bus.req, 1'b0);
        chk("mis_stall", stall_o, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("mis_pulse", mis_o,      1'b1);
        chk("mis_rdvld", rd_o.valid, 1'b0);
        @(negedge clk);
        #1;
        chk("mis_clear", mis_o, 1'b0);

        // LW 0x200 never granted: aborts after 4 waiting cycles
        run_load(LW, 32'h200, 32'h0, -1, -1, stalls, reqs);
        chk("to_stalls", stalls, 5);
        chk("to_reqs",   reqs,   5);
        chk("to_berr",   berr_o, 1'b1);
        chk("to_rdvld",  rd_o.valid, 1'b0);
        @(negedge clk);
        #1;
        chk("to_berr_clear", berr_o, 1'b0);

        // Reset while waiting for rvalid
        @(negedge clk);
        op = LW; addr = 32'h300;
        rd_in.addr = 5'd4; rd_in.data = 32'h0; rd_in.valid = 1'b1;
        bus.gnt = 1'b1;
        #1;
        chk("rm_req_start", bus.req, 1'b1);
        @(negedge clk);
        bus.gnt = 1'b0;
        #1;
        chk("rm_waiting", stall_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("rm_req",   bus.req, 1'b0);
        chk("rm_stall", stall_o, 1'b0);
        chk("rm_rd",    rd_o,    38'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hFFFFFFFF;
        #1;
        chk("rm_late_stall", stall_o, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("rm_late_rdvld", rd_o.valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
